// File: rtl/tub_scan_driver.sv
// Scans two 4-digit seven-segment groups in parallel from a per-frame snapshot.
// Optional leading-zero blanking is compiled in when TUB_LZB_EN is defined.
module tub_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] digits,
    input  logic [7:0]  dot_mask,
    input  logic [7:0]  blank_mask,
    output logic [7:0]  tub_segments1,
    output logic [7:0]  tub_segments2,
    output logic [7:0]  tub_select,
    output logic        frame_tick
);

    function automatic logic [7:0] seg7(input logic [3:0] c);
        case (c)
            4'h0: seg7 = 8'hFC;  4'h1: seg7 = 8'h60;  4'h2: seg7 = 8'hDA;  4'h3: seg7 = 8'hF2;
            4'h4: seg7 = 8'h66;  4'h5: seg7 = 8'hB6;  4'h6: seg7 = 8'hBE;  4'h7: seg7 = 8'hE0;
            4'h8: seg7 = 8'hFE;  4'h9: seg7 = 8'hF6;  4'hA: seg7 = 8'hEE;  4'hB: seg7 = 8'h3E;
            4'hC: seg7 = 8'h9C;  4'hD: seg7 = 8'h7A;  4'hE: seg7 = 8'h9E;  default: seg7 = 8'h8E;
        endcase
    endfunction

`ifdef TUB_LZB_EN
    // Blank from the group's left edge while digits are undotted zeros; position 0 is exempt.
    function automatic logic [3:0] lzb(input logic [15:0] d, input logic [3:0] dp);
        logic run;
        lzb = '0;
        run = 1'b1;
        for (int p = 3; p >= 1; p--) begin
            run    = run & (d[4*p +: 4] == 4'h0) & ~dp[p];
            lzb[p] = run;
        end
    endfunction
`endif

    logic             en_q, en_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [31:0]      snap_dig_q, snap_dig_d;
    logic [7:0]       snap_dot_q, snap_dot_d;
    logic [7:0]       snap_blk_q, snap_blk_d;
    logic [7:0]       seg1_q, seg1_d, seg2_q, seg2_d, sel_q, sel_d;
    logic             tick_q, tick_d;

    logic        frame_start, wrap, new_frame;
    logic [1:0]  slot_nxt;
    logic [2:0]  idx_l, idx_r;
    logic [31:0] src_dig;
    logic [7:0]  src_dot, blank_eff;
    logic [7:0]  seg_l, seg_r, sel_nxt;

    always_comb begin
        frame_start = enable & ~en_q;
        wrap        = enable & en_q & (div_cnt_q == CNT_W'(SCAN_DIV - 1));
        new_frame   = frame_start | (wrap & (slot_q == 2'd3));
        slot_nxt    = frame_start ? 2'd0 : slot_q + 2'd1;
        // A new frame shows the values being captured this edge, not the stale snapshot.
        src_dig     = new_frame ? digits   : snap_dig_q;
        src_dot     = new_frame ? dot_mask : snap_dot_q;
        blank_eff   = new_frame ? blank_mask : snap_blk_q;
`ifdef TUB_LZB_EN
        blank_eff   = blank_eff | {lzb(src_dig[31:16], src_dot[7:4]), lzb(src_dig[15:0], src_dot[3:0])};
`endif
        idx_l   = {1'b1, ~slot_nxt};
        idx_r   = {1'b0, ~slot_nxt};
        seg_l   = blank_eff[idx_l] ? 8'h00 : (seg7(src_dig[{idx_l, 2'b00} +: 4]) | {7'b0, src_dot[idx_l]});
        seg_r   = blank_eff[idx_r] ? 8'h00 : (seg7(src_dig[{idx_r, 2'b00} +: 4]) | {7'b0, src_dot[idx_r]});
        sel_nxt = (8'd1 << idx_l) | (8'd1 << idx_r);
    end

    always_comb begin
        en_d       = enable;
        div_cnt_d  = div_cnt_q;
        slot_d     = slot_q;
        snap_dig_d = snap_dig_q;
        snap_dot_d = snap_dot_q;
        snap_blk_d = snap_blk_q;
        seg1_d     = seg1_q;
        seg2_d     = seg2_q;
        sel_d      = sel_q;
        tick_d     = 1'b0;
        if (!enable) begin
            div_cnt_d = '0;
            slot_d    = '0;
            seg1_d    = '0;
            seg2_d    = '0;
            sel_d     = '0;
        end else if (frame_start || wrap) begin
            div_cnt_d = '0;
            slot_d    = slot_nxt;
            seg1_d    = seg_l;
            seg2_d    = seg_r;
            sel_d     = sel_nxt;
            tick_d    = new_frame;
            if (new_frame) begin
                snap_dig_d = digits;
                snap_dot_d = dot_mask;
                snap_blk_d = blank_mask;
            end
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q       <= 1'b0;
            div_cnt_q  <= '0;
            slot_q     <= '0;
            snap_dig_q <= '0;
            snap_dot_q <= '0;
            snap_blk_q <= '0;
            seg1_q     <= '0;
            seg2_q     <= '0;
            sel_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            div_cnt_q  <= div_cnt_d;
            slot_q     <= slot_d;
            snap_dig_q <= snap_dig_d;
            snap_dot_q <= snap_dot_d;
            snap_blk_q <= snap_blk_d;
            seg1_q     <= seg1_d;
            seg2_q     <= seg2_d;
            sel_q      <= sel_d;
            tick_q     <= tick_d;
        end
    end

    assign tub_segments1 = seg1_q;
    assign tub_segments2 = seg2_q;
    assign tub_select    = sel_q;
    assign frame_tick    = tick_q;

endmodule
